muxn_skid: RTL and testbench
============================

Name: muxn_skid

Overview:
- Parametrised N-way, WIDTH-bit multiplexer with a registered output and a valid/ready handshake on both sides.
- Selected data passes through a 2-entry skid buffer, so downstream backpressure never corrupts or drops data.
- Used between pipeline stages in the MIPS datapath (writeback/forward source select, memory-return steering) where a registered, stallable, flushable select is needed.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), width of the select field; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous reset, active low.
- din  input  NUM_IN*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  binary select, sampled with the transfer.
- in_valid  input  1  upstream offers din/sel.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  discard all buffered entries.
- dout  output  WIDTH  selected data of the head entry.
- dout_err  output  1  head entry was captured with sel >= NUM_IN.
- out_valid  output  1  dout is valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset is synchronous on a rising clk with resetn=0. It clears both entries. Reset values: out_valid=0, dout=0, dout_err=0, in_ready=1. It overrides flush and all handshakes and aborts any buffered data.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Select rule, evaluated at capture:
  - sel < NUM_IN: the entry stores din[sel*WIDTH +: WIDTH] and err=0.
  - sel >= NUM_IN (possible only when NUM_IN is not a power of 2): the entry stores all-zero data and err=1.
- Storage is a main register (drives dout, dout_err and out_valid) plus a skid register (skid_valid).
- in_ready = !skid_valid. It is a pure register output with no combinational path from out_ready.
- Latency: a captured word appears on dout in the cycle after capture. Throughput is 1 word/cycle while out_ready=1.
- Next-state rules per cycle (evaluated with the pre-edge values):
  - Main empty, input transfer: main <= captured word.
  - Main full, output transfer, skid full: main <= skid, skid empties. in_ready is 0, so no capture happens this cycle.
  - Main full, output transfer, skid empty, input transfer: main <= captured word.
  - Main full, output transfer, skid empty, no input: main empties.
  - Main full, no output transfer, input transfer: skid <= captured word (skid was empty because in_ready=1).
  - Main full, no output transfer, no input: hold.
- Ordering is strictly FIFO: skid data always leaves before any later capture.
- dout and dout_err hold stable while out_valid=1 and out_ready=0.
- When the main entry is empty: out_valid=0, and dout/dout_err keep their last value. They are don't-care and are not checked.
- Flush (resetn=1):
  - Next cycle: both entries are empty, out_valid=0, in_ready=1.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still completes; downstream may consume the current head.
- Full condition: both entries valid → in_ready=0, and in_valid is ignored.
- Empty condition: out_valid=0, and out_ready is ignored.

Test Plan:
- Reset/basic: hold resetn=0 for 2 cycles, then release. NUM_IN=4, din={4'hD..,C..,B..,A..} with lane0=32'hA0A0A0A0. Present sel=2, in_valid=1, out_ready=1 → one cycle later out_valid=1, dout=lane2 value, dout_err=0. Check in_ready=1 throughout.
- Streaming: 8 back-to-back words, sel cycling 0,1,2,3, out_ready=1 → 8 consecutive out_valid cycles, outputs in order, no bubbles.
- Backpressure/skid: out_ready=0, send word X (sel=1) then Y (sel=3) → main=X, skid=Y, in_ready=0 after the 2nd capture. Raise out_ready → X then Y in consecutive cycles, in_ready returns to 1 the cycle after X leaves.
- Out-of-range select: NUM_IN=3, send sel=3 → dout=0, dout_err=1. The next word with sel=0 → dout_err=0.
- Flush: fill both entries, then assert flush with in_valid=1 and out_ready=0 → next cycle out_valid=0, in_ready=1, and no flushed or flush-cycle data ever appears on dout.
- Reset mid-operation: both entries full, assert resetn=0 for 1 cycle with in_valid=1 → next cycle out_valid=0, dout=0, in_ready=1, and the entries are not recovered after release.

Source files
------------

// File: rtl/muxn_skid.sv
// N-way WIDTH-bit select with a registered output and a 2-entry skid buffer.
// Valid/ready on both sides. Capture-time selection and error flag for out-of-range sel.
module muxn_skid #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Head entry drives the outputs; the skid entry absorbs one word of backpressure.
  logic             main_valid, main_valid_nxt;
  logic [WIDTH-1:0] main_data,  main_data_nxt;
  logic             main_err,   main_err_nxt;
  logic             skid_valid, skid_valid_nxt;
  logic [WIDTH-1:0] skid_data,  skid_data_nxt;
  logic             skid_err,   skid_err_nxt;

  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign dout      = main_data;
  assign dout_err  = main_err;

  // Selection compares against every legal index, so an out-of-range sel
  // falls through to the all-zero, err=1 default without indexing past din.
  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_data = din[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  // Words offered during a flush are dropped, never captured.
  assign in_xfer  = in_valid & in_ready & !flush;
  assign out_xfer = main_valid & out_ready;

  always_comb begin
    main_valid_nxt = main_valid;
    main_data_nxt  = main_data;
    main_err_nxt   = main_err;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    skid_err_nxt   = skid_err;

    if (flush) begin
      // A head consumed in this cycle has already left; both entries just empty.
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (!main_valid) begin
      if (in_xfer) begin
        main_valid_nxt = 1'b1;
        main_data_nxt  = cap_data;
        main_err_nxt   = cap_err;
      end
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_data_nxt  = skid_data;
        main_err_nxt   = skid_err;
        skid_valid_nxt = 1'b0;
      end else if (in_xfer) begin
        main_data_nxt  = cap_data;
        main_err_nxt   = cap_err;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = cap_data;
      skid_err_nxt   = cap_err;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: payload registers are reset too; dout must read zero after reset
      // and the skid payload is kept deterministic for the same reason.
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      main_data  <= main_data_nxt;
      main_err   <= main_err_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_err   <= skid_err_nxt;
    end
  end

endmodule

// File: tb/tb_muxn_skid.sv
// Directed bench for muxn_skid: a 4-input instance for the main features and a
// 3-input instance sharing the same controls for the out-of-range select case.
module tb_muxn_skid;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] din4;
  logic [95:0]  din3;
  logic [1:0]   sel;
  logic         in_valid;
  logic         flush;
  logic         out_ready;

  logic         in_ready4, out_valid4, dout_err4;
  logic [31:0]  dout4;
  logic         in_ready3, out_valid3, dout_err3;
  logic [31:0]  dout3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muxn_skid #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .resetn(resetn), .din(din4), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .flush(flush), .dout(dout4), .dout_err(dout_err4),
    .out_valid(out_valid4), .out_ready(out_ready)
  );

  muxn_skid #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .resetn(resetn), .din(din3), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .flush(flush), .dout(dout3), .dout_err(dout_err3),
    .out_valid(out_valid3), .out_ready(out_ready)
  );

  // Lane k of word i: byte (A0 + 16*k + i) repeated, so lane0 of word 0 is A0A0A0A0.
  function automatic logic [31:0] lv(input int k, input int i);
    logic [7:0] b;
    b = 8'hA0 + 8'(k * 16) + 8'(i);
    return {4{b}};
  endfunction

  task automatic set_din(input int i);
    for (int k = 0; k < 4; k++) din4[k*32 +: 32] = lv(k, i);
    for (int k = 0; k < 3; k++) din3[k*32 +: 32] = lv(k, i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; sel = 2'd0;
    set_din(0);
    tick(); tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid4); end
    checks++; if (dout4 !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 00000000", dout4); end
    checks++; if (dout_err4 !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", dout_err4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready4); end
    resetn = 1'b1; sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid4); end
    checks++; if (dout4 !== 32'hC0C0C0C0) begin errors++; $display("FAIL basic_dout got %h want c0c0c0c0", dout4); end
    checks++; if (dout_err4 !== 1'b0) begin errors++; $display("FAIL basic_err got %0b want 0", dout_err4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b want 1", in_ready4); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", out_valid4); end
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4);
      set_din(i);
      tick();
      checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid4); end
      checks++; if (dout4 !== lv(i % 4, i)) begin errors++; $display("FAIL stream_dout[%0d] got %h want %h", i, dout4, lv(i % 4, i)); end
      checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready4); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL stream_end got %0b want 0", out_valid4); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd1; set_din(1);                       // X = B1B1B1B1
    tick();
    checks++; if (dout4 !== 32'hB1B1B1B1) begin errors++; $display("FAIL bp_x_head got %h want b1b1b1b1", dout4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp_ready_after_x got %0b want 1", in_ready4); end
    sel = 2'd3; set_din(2);                       // Y = D2D2D2D2
    tick();
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", in_ready4); end
    checks++; if (dout4 !== 32'hB1B1B1B1) begin errors++; $display("FAIL bp_x_hold got %h want b1b1b1b1", dout4); end
    sel = 2'd0; set_din(3);                       // offered while full, must be ignored
    tick();
    checks++; if (dout4 !== 32'hB1B1B1B1 || out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_stall got %h/%0b want b1b1b1b1/1", dout4, out_valid4); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (dout4 !== 32'hD2D2D2D2 || out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_y_out got %h/%0b want d2d2d2d2/1", dout4, out_valid4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b want 1", in_ready4); end
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", out_valid4); end
  endtask

  task automatic test_out_of_range();
    in_valid = 1'b1; out_ready = 1'b1;
    sel = 2'd3; set_din(4);
    tick();
    checks++; if (out_valid3 !== 1'b1) begin errors++; $display("FAIL oor_valid got %0b want 1", out_valid3); end
    checks++; if (dout3 !== 32'h0) begin errors++; $display("FAIL oor_dout got %h want 00000000", dout3); end
    checks++; if (dout_err3 !== 1'b1) begin errors++; $display("FAIL oor_err got %0b want 1", dout_err3); end
    checks++; if (dout4 !== 32'hD4D4D4D4 || dout_err4 !== 1'b0) begin errors++; $display("FAIL oor_n4 got %h/%0b want d4d4d4d4/0", dout4, dout_err4); end
    sel = 2'd0; set_din(5);
    tick();
    checks++; if (dout3 !== 32'hA5A5A5A5) begin errors++; $display("FAIL oor_next_dout got %h want a5a5a5a5", dout3); end
    checks++; if (dout_err3 !== 1'b0) begin errors++; $display("FAIL oor_next_err got %0b want 0", dout_err3); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd1; set_din(6); tick();
    sel = 2'd2; set_din(7); tick();
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL flush_fill got %0b want 0", in_ready4); end
    flush = 1'b1; sel = 2'd0; set_din(0);
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready4); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] got %0b dout %h want 0", i, out_valid4, dout4); end
    end
    in_valid = 1'b1; sel = 2'd3; set_din(1);
    tick();
    checks++; if (dout4 !== 32'hD1D1D1D1 || out_valid4 !== 1'b1) begin errors++; $display("FAIL flush_after got %h/%0b want d1d1d1d1/1", dout4, out_valid4); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd2; set_din(2); tick();
    sel = 2'd1; set_din(3); tick();
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL rst_mid_fill got %0b want 0", in_ready4); end
    resetn = 1'b0;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", out_valid4); end
    checks++; if (dout4 !== 32'h0 || dout_err4 !== 1'b0) begin errors++; $display("FAIL rst_mid_dout got %h/%0b want 00000000/0", dout4, dout_err4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %0b want 1", in_ready4); end
    resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rst_mid_recover[%0d] got %0b want 0", i, out_valid4); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
